pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: mem-wait, mul/div, branch-flush and load-use stall/bubble generation.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic [4:0] ID_EX_rw,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_valid,
    input  logic       EX_is_muldiv,
    input  logic       md_done,
    input  logic       dmem_req,
    input  logic       dmem_data_ok,
    input  logic       imem_req,
    input  logic       imem_data_ok,
    input  logic       branch_taken,
    output logic       stall_front,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       bubble_ex,
    output logic       bubble_mem,
    output logic       bubble_wb,
    output logic       flush_id,
    output logic       md_start
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] load_use_cnt
`endif
);

    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_e;

    state_e state_q, state_d;
    logic   flush_pending_q, flush_pending_d;
    logic   mem_busy;
    logic   load_use;
    logic   md_hold;
    logic   md_launch;
    logic   branch_honoured;
`ifdef HAZARD_PERF_EN
    logic   lu_stall;
`endif

    assign mem_busy  = dmem_req & ~dmem_data_ok;
    assign load_use  = ID_EX_valid & ID_EX_MemRead & (ID_EX_rw != 5'd0)
                     & ((ID_EX_rw == ID_rs1) | (ID_EX_rw == ID_rs2));
    assign md_hold   = (state_q == MD_WAIT) & ~md_done;
    assign md_launch = (state_q == RUN) & EX_is_muldiv;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        branch_honoured = 1'b0;
        stall_front     = 1'b0;
        stall_ex        = 1'b0;
        stall_mem       = 1'b0;
        bubble_ex       = 1'b0;
        bubble_mem      = 1'b0;
        bubble_wb       = 1'b0;
        flush_id        = 1'b0;
        md_start        = 1'b0;
`ifdef HAZARD_PERF_EN
        lu_stall        = 1'b0;
`endif

        if (mem_busy) begin
            // Whole pipe freezes; FSM and pending flush hold until memory answers.
            stall_front = 1'b1;
            stall_ex    = 1'b1;
            stall_mem   = 1'b1;
            bubble_wb   = 1'b1;
        end else begin
            if (md_hold) begin
                stall_front = 1'b1;
                stall_ex    = 1'b1;
                bubble_mem  = 1'b1;
            end else if (md_launch) begin
                md_start    = 1'b1;
                stall_front = 1'b1;
                stall_ex    = 1'b1;
                bubble_mem  = 1'b1;
                state_d     = MD_WAIT;
            end else begin
                // md_done in MD_WAIT releases the stall this very cycle.
                state_d = RUN;
                if (branch_taken) begin
                    branch_honoured = 1'b1;
                    flush_id        = 1'b1;
                    bubble_ex       = 1'b1;
                end else if (load_use) begin
                    stall_front = 1'b1;
                    bubble_ex   = 1'b1;
`ifdef HAZARD_PERF_EN
                    lu_stall    = 1'b1;
`endif
                end
            end

            if (flush_pending_q) begin
                if (imem_data_ok) begin
                    flush_id        = 1'b1;
                    flush_pending_d = 1'b0;
                end
            end else if (branch_honoured & imem_req & ~imem_data_ok) begin
                flush_pending_d = 1'b1;
            end
        end

        if (!reset) begin
            stall_front = 1'b0;
            stall_ex    = 1'b0;
            stall_mem   = 1'b0;
            bubble_ex   = 1'b0;
            bubble_mem  = 1'b0;
            bubble_wb   = 1'b0;
            flush_id    = 1'b0;
            md_start    = 1'b0;
`ifdef HAZARD_PERF_EN
            lu_stall    = 1'b0;
`endif
        end
    end

    // NOTE: state flops use non-blocking assignments and clear asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= RUN;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] load_use_cnt_q, load_use_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(stall_front);
        load_use_cnt_d = load_use_cnt_q + 32'(lu_stall);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
            load_use_cnt_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            load_use_cnt_q <= load_use_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign load_use_cnt = load_use_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rw;
        logic       memread;
        logic       valid;
        logic       muldiv;
        logic       md_done;
        logic       dreq;
        logic       dok;
        logic       ireq;
        logic       iok;
        logic       br;
    } in_t;

    // Output bundle order: stall_front, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, flush_id, md_start
    typedef struct packed {
        logic sf, se, sm, bex, bmem, bwb, fid, mds;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs1, ID_rs2, ID_EX_rw;
    logic       ID_EX_MemRead, ID_EX_valid, EX_is_muldiv, md_done;
    logic       dmem_req, dmem_data_ok, imem_req, imem_data_ok, branch_taken;
    logic       stall_front, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, flush_id, md_start;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, load_use_cnt;
`endif

    pipeline_hazard_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_EX_rw      (ID_EX_rw),
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_valid   (ID_EX_valid),
        .EX_is_muldiv  (EX_is_muldiv),
        .md_done       (md_done),
        .dmem_req      (dmem_req),
        .dmem_data_ok  (dmem_data_ok),
        .imem_req      (imem_req),
        .imem_data_ok  (imem_data_ok),
        .branch_taken  (branch_taken),
        .stall_front   (stall_front),
        .stall_ex      (stall_ex),
        .stall_mem     (stall_mem),
        .bubble_ex     (bubble_ex),
        .bubble_mem    (bubble_mem),
        .bubble_wb     (bubble_wb),
        .flush_id      (flush_id),
        .md_start      (md_start)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .load_use_cnt  (load_use_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: "a mul/div is outstanding" and "a fetch must be flushed on arrival".
    bit          m_md_busy = 1'b0;
    bit          m_pend    = 1'b0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_lu_cnt    = 0;
    bit          m_lu_event;

    function automatic bit is_load_use(input in_t v);
        return v.valid && v.memread && (v.rw != 0) && (v.rw == v.rs1 || v.rw == v.rs2);
    endfunction

    function automatic out_t model_out(input in_t v);
        out_t e = '0;
        m_lu_event = 1'b0;
        if (!v.rst_n) return e;
        if (v.dreq && !v.dok) begin
            e.sf = 1; e.se = 1; e.sm = 1; e.bwb = 1;
            return e;
        end
        if (m_md_busy && !v.md_done) begin
            e.sf = 1; e.se = 1; e.bmem = 1;
        end else if (!m_md_busy && v.muldiv) begin
            e.mds = 1; e.sf = 1; e.se = 1; e.bmem = 1;
        end else if (v.br) begin
            e.fid = 1; e.bex = 1;
        end else if (is_load_use(v)) begin
            e.sf = 1; e.bex = 1;
            m_lu_event = 1'b1;
        end
        if (m_pend && v.iok) e.fid = 1;
        return e;
    endfunction

    task automatic model_update(input in_t v, input out_t e);
        bit busy;
        bit honoured;
        if (!v.rst_n) begin
            m_md_busy = 0; m_pend = 0; m_stall_cnt = 0; m_lu_cnt = 0;
            return;
        end
        m_stall_cnt += 32'(e.sf);
        m_lu_cnt    += 32'(m_lu_event);
        busy = v.dreq && !v.dok;
        if (busy) return;
        honoured = v.br && !e.se;
        if (m_md_busy) m_md_busy = !v.md_done;
        else           m_md_busy = v.muldiv;
        if (m_pend) m_pend = !v.iok;
        else        m_pend = honoured && v.ireq && !v.iok;
    endtask

    function automatic in_t idle();
        in_t v = '0;
        v.rst_n = 1'b1;
        return v;
    endfunction

    task automatic drive(input in_t v);
        reset         = v.rst_n;
        ID_rs1        = v.rs1;
        ID_rs2        = v.rs2;
        ID_EX_rw      = v.rw;
        ID_EX_MemRead = v.memread;
        ID_EX_valid   = v.valid;
        EX_is_muldiv  = v.muldiv;
        md_done       = v.md_done;
        dmem_req      = v.dreq;
        dmem_data_ok  = v.dok;
        imem_req      = v.ireq;
        imem_data_ok  = v.iok;
        branch_taken  = v.br;
    endtask

    // One cycle: drive just after the rising edge, compare at the falling edge, advance the model.
    task automatic step(input in_t v, input string tag);
        out_t e, o;
        drive(v);
        @(negedge clk);
        e = model_out(v);
        o = {stall_front, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, flush_id, md_start};
        n_vec++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: outputs observed %b expected %b", tag, o, e);
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        assert (stall_cycles === m_stall_cnt && load_use_cnt === m_lu_cnt) else begin
            n_fail++;
            $error("FAIL %s_cnt: observed %h/%h expected %h/%h", tag,
                   stall_cycles, load_use_cnt, m_stall_cnt, m_lu_cnt);
        end
`endif
        model_update(v, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t v;

        // Reset held with noisy inputs: everything must read 0.
        v = idle(); v.rst_n = 0; v.muldiv = 1; v.dreq = 1; v.br = 1; v.valid = 1; v.memread = 1;
        v.rw = 5'd3; v.rs1 = 5'd3;
        drive(v);
        #12;
        step(v, "reset_hold");
        step(idle(), "reset_release");

        // Load-use on rs2, then gone, then rw=0 which must not stall.
        v = idle(); v.valid = 1; v.memread = 1; v.rw = 5'd5; v.rs2 = 5'd5;
        step(v, "load_use_rs2");
        step(idle(), "load_use_after");
        v.rw = 5'd0; v.rs2 = 5'd0;
        step(v, "load_use_x0");

        // Mul/div with md_done four cycles after launch.
        v = idle(); v.muldiv = 1;
        step(v, "md_c0");
        step(v, "md_c1");
        step(v, "md_c2");
        step(v, "md_c3");
        v.muldiv = 0; v.md_done = 1;
        step(v, "md_c4_done");
        step(idle(), "md_after");

        // Memory wait in the middle of MD_WAIT.
        v = idle(); v.muldiv = 1;
        step(v, "mdmem_start");
        v = idle(); v.dreq = 1;
        for (int i = 0; i < 3; i++) step(v, "mdmem_busy");
        step(idle(), "mdmem_still_wait");
        v = idle(); v.md_done = 1;
        step(v, "mdmem_done");

        // Branch while a fetch is in flight; response two cycles later.
        v = idle(); v.br = 1; v.ireq = 1;
        step(v, "br_flight");
        v = idle(); v.ireq = 1;
        step(v, "br_gap1");
        step(v, "br_gap2");
        v.iok = 1;
        step(v, "br_data_ok");
        step(idle(), "br_after");

        // Branch overrides a simultaneous load-use; branch ignored while mul/div stalls.
        v = idle(); v.br = 1; v.valid = 1; v.memread = 1; v.rw = 5'd7; v.rs1 = 5'd7;
        step(v, "br_over_lu");
        v = idle(); v.muldiv = 1; v.br = 1;
        step(v, "br_md_start");
        v.muldiv = 0;
        step(v, "br_md_wait");

        // Reset mid-MD_WAIT (still outstanding from above), then a stray md_done.
        v = idle(); v.rst_n = 0; v.muldiv = 1;
        step(v, "rst_mid_md");
        v = idle(); v.md_done = 1;
        step(v, "rst_md_done_ignored");

        // Reset with a flush pending: the later response must not flush.
        v = idle(); v.br = 1; v.ireq = 1;
        step(v, "pend_arm");
        v = idle(); v.rst_n = 0;
        step(v, "pend_reset");
        v = idle(); v.ireq = 1; v.iok = 1;
        step(v, "pend_abandoned");

`ifdef HAZARD_PERF_EN
        // Counter wrap: preload just below the limit, then two stall cycles.
        dut.stall_cycles_q = 32'hFFFF_FFFF;
        m_stall_cnt        = 32'hFFFF_FFFF;
        v = idle(); v.valid = 1; v.memread = 1; v.rw = 5'd9; v.rs1 = 5'd9;
        step(v, "wrap_stall1");
        step(v, "wrap_stall2");
        step(idle(), "wrap_read1");
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            v         = idle();
            v.rst_n   = ($urandom_range(0, 79) != 0);
            v.rs1     = 5'($urandom_range(0, 3));
            v.rs2     = 5'($urandom_range(0, 3));
            v.rw      = 5'($urandom_range(0, 3));
            v.memread = ($urandom_range(0, 1) == 1);
            v.valid   = ($urandom_range(0, 3) != 0);
            v.muldiv  = ($urandom_range(0, 5) == 0);
            v.md_done = ($urandom_range(0, 4) == 0);
            v.dreq    = ($urandom_range(0, 2) == 0);
            v.dok     = ($urandom_range(0, 1) == 1);
            v.ireq    = ($urandom_range(0, 1) == 1);
            v.iok     = ($urandom_range(0, 2) == 0);
            v.br      = ($urandom_range(0, 5) == 0);
            step(v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
